// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage. Takes completed results from the load/store stage
//   over a valid/ready handshake, extracts and extends load data, and drives
//   the register-file write port one cycle after acceptance. The registered
//   write port also serves as the decode-stage bypass source.
//
// Ports
//   clk_i                  clock
//   rst_ni                 asynchronous active-low reset
//   input_valid_i          upstream result valid
//   input_ready_o          stage can accept this cycle (~halt_i)
//   input_reg_write_i      result targets a register
//   input_reg_addr_i       destination register
//   input_reg_data_i       ALU result, or raw aligned memory word for loads
//   input_load_i           result is a load
//   input_load_size_i      00 byte, 01 half, 10 word, 11 illegal
//   input_load_unsigned_i  zero-extend instead of sign-extend
//   input_load_offset_i    byte offset of the access within the word
//   halt_i                 debug/stall request, blocks acceptance
//   reg_write_o            register-file write enable
//   reg_addr_o             register-file write address
//   reg_data_o             register-file write data
//   misaligned_o           one-cycle pulse on a faulting load
//   retired_count_o        number of non-faulting accepted results
module writeback_stage #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   input_valid_i,
  output logic                   input_ready_o,
  input  logic                   input_reg_write_i,
  input  logic [4:0]             input_reg_addr_i,
  input  logic [31:0]            input_reg_data_i,
  input  logic                   input_load_i,
  input  logic [1:0]             input_load_size_i,
  input  logic                   input_load_unsigned_i,
  input  logic [1:0]             input_load_offset_i,
  input  logic                   halt_i,
  output logic                   reg_write_o,
  output logic [4:0]             reg_addr_o,
  output logic [31:0]            reg_data_o,
  output logic                   misaligned_o,
  output logic [COUNT_WIDTH-1:0] retired_count_o
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic        accept;
  logic        misaligned;
  logic        size_fault;
  logic [31:0] shifted;
  logic [31:0] extracted;

  // The stage never backpressures on its own; only a halt request stalls it.
  assign input_ready_o = ~halt_i;
  assign accept        = input_valid_i & input_ready_o;

  always_comb begin
    size_fault = 1'b0;
    case (input_load_size_i)
      SIZE_BYTE: size_fault = 1'b0;
      SIZE_HALF: size_fault = input_load_offset_i[0];
      SIZE_WORD: size_fault = (input_load_offset_i != 2'b00);
      default:   size_fault = 1'b1;
    endcase
  end

  // Only loads can fault; size/offset fields are ignored for ALU results.
  assign misaligned = input_load_i & size_fault;

  // Move the addressed byte lane down to bit 0 before extending.
  assign shifted = input_reg_data_i >> {input_load_offset_i, 3'b000};

  always_comb begin
    extracted = input_reg_data_i;
    if (input_load_i) begin
      case (input_load_size_i)
        SIZE_BYTE: extracted = {{24{shifted[7] & ~input_load_unsigned_i}}, shifted[7:0]};
        SIZE_HALF: extracted = {{16{shifted[15] & ~input_load_unsigned_i}}, shifted[15:0]};
        default:   extracted = shifted;
      endcase
    end
  end

  // Write port: enable and fault flag are single-cycle pulses, while address
  // and data hold between accepts so the bypass view stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_write_o  <= 1'b0;
      reg_addr_o   <= '0;
      reg_data_o   <= '0;
      misaligned_o <= 1'b0;
    end else if (accept) begin
      reg_write_o  <= input_reg_write_i & (input_reg_addr_i != 5'd0) & ~misaligned;
      reg_addr_o   <= input_reg_addr_i;
      reg_data_o   <= extracted;
      misaligned_o <= misaligned;
    end else begin
      reg_write_o  <= 1'b0;
      misaligned_o <= 1'b0;
    end
  end

  // Writes to x0 still retire; only faulting loads are excluded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_count_o <= '0;
    end else if (accept && !misaligned) begin
      retired_count_o <= retired_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
//   Directed and randomized bench for writeback_stage. A second instance with
//   a 4-bit counter shares all inputs so counter wrap-around is reached quickly.
module tb_writeback_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        input_valid_i = 1'b0;
  logic        input_ready_o;
  logic        input_reg_write_i = 1'b0;
  logic [4:0]  input_reg_addr_i = '0;
  logic [31:0] input_reg_data_i = '0;
  logic        input_load_i = 1'b0;
  logic [1:0]  input_load_size_i = '0;
  logic        input_load_unsigned_i = 1'b0;
  logic [1:0]  input_load_offset_i = '0;
  logic        halt_i = 1'b0;
  logic        reg_write_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_o;
  logic        misaligned_o;
  logic [31:0] retired_count_o;

  logic        wrap_ready;
  logic        wrap_write;
  logic [4:0]  wrap_addr;
  logic [31:0] wrap_data;
  logic        wrap_misaligned;
  logic [3:0]  wrap_count;

  always #5 clk_i = ~clk_i;

  writeback_stage #(.COUNT_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .input_valid_i(input_valid_i), .input_ready_o(input_ready_o),
    .input_reg_write_i(input_reg_write_i), .input_reg_addr_i(input_reg_addr_i),
    .input_reg_data_i(input_reg_data_i), .input_load_i(input_load_i),
    .input_load_size_i(input_load_size_i), .input_load_unsigned_i(input_load_unsigned_i),
    .input_load_offset_i(input_load_offset_i), .halt_i(halt_i),
    .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
    .misaligned_o(misaligned_o), .retired_count_o(retired_count_o)
  );

  writeback_stage #(.COUNT_WIDTH(4)) wrap_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .input_valid_i(input_valid_i), .input_ready_o(wrap_ready),
    .input_reg_write_i(input_reg_write_i), .input_reg_addr_i(input_reg_addr_i),
    .input_reg_data_i(input_reg_data_i), .input_load_i(input_load_i),
    .input_load_size_i(input_load_size_i), .input_load_unsigned_i(input_load_unsigned_i),
    .input_load_offset_i(input_load_offset_i), .halt_i(halt_i),
    .reg_write_o(wrap_write), .reg_addr_o(wrap_addr), .reg_data_o(wrap_data),
    .misaligned_o(wrap_misaligned), .retired_count_o(wrap_count)
  );

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  // Reference model state: what the outputs must show after the next edge.
  logic        exp_write = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_data_known = 1'b1;
  logic        exp_mis = 1'b0;
  longint      exp_count = 0;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Load rules stated arithmetically: pick nbytes starting at byte 'off',
  // then sign-extend by subtracting 2^(8*nbytes) when the top bit is set.
  function automatic logic [31:0] modelExtract(input logic [31:0] data, input logic load,
                                               input logic [1:0] size, input logic uns,
                                               input logic [1:0] off);
    longint word, val, span;
    int nbytes;
    if (!load) return data;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    word = longint'(data);
    span = longint'(1) << (8 * nbytes);
    val = (word / (longint'(1) << (8 * int'(off)))) % span;
    if (!uns && val >= span / 2) val = val - span;
    return val[31:0];
  endfunction

  function automatic logic modelFault(input logic load, input logic [1:0] size, input logic [1:0] off);
    if (!load) return 1'b0;
    if (size == 2'd3) return 1'b1;
    if (size == 2'd2) return off != 2'd0;
    if (size == 2'd1) return (off % 2) == 1;
    return 1'b0;
  endfunction

  task checkOutput(input string step);
    checkValue({step, ".reg_write"}, {31'b0, reg_write_o}, {31'b0, exp_write});
    checkValue({step, ".reg_addr"}, {27'b0, reg_addr_o}, {27'b0, exp_addr});
    if (exp_data_known)
      checkValue({step, ".reg_data"}, reg_data_o, exp_data);
    checkValue({step, ".misaligned"}, {31'b0, misaligned_o}, {31'b0, exp_mis});
    checkValue({step, ".retired"}, retired_count_o, exp_count[31:0]);
    checkValue({step, ".wrap_retired"}, {28'b0, wrap_count}, {28'b0, exp_count[3:0]});
  endtask

  // Drive one cycle of inputs shortly after a rising edge, confirm the
  // combinational ready, then let the model and DUT advance across the edge.
  task applyStimulus(input string step, input logic valid, input logic halt,
                     input logic wr, input logic [4:0] addr, input logic [31:0] data,
                     input logic load, input logic [1:0] size, input logic uns,
                     input logic [1:0] off);
    logic fault;
    input_valid_i = valid;
    halt_i = halt;
    input_reg_write_i = wr;
    input_reg_addr_i = addr;
    input_reg_data_i = data;
    input_load_i = load;
    input_load_size_i = size;
    input_load_unsigned_i = uns;
    input_load_offset_i = off;
    #1;
    checkValue({step, ".ready"}, {31'b0, input_ready_o}, {31'b0, !halt});
    if (valid && !halt) begin
      fault = modelFault(load, size, off);
      exp_write = wr && (addr != 5'd0) && !fault;
      exp_addr = addr;
      exp_mis = fault;
      exp_data_known = !fault;
      if (!fault) begin
        exp_data = modelExtract(data, load, size, uns, off);
        exp_count = (exp_count + 1) % (longint'(1) << 32);
      end
    end else begin
      exp_write = 1'b0;
      exp_mis = 1'b0;
    end
    @(posedge clk_i);
    #1;
    checkOutput(step);
  endtask

  task idle(input string step);
    applyStimulus(step, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  task loadStep(input string step, input logic [31:0] data, input logic [1:0] size,
                input logic uns, input logic [1:0] off);
    applyStimulus(step, 1'b1, 1'b0, 1'b1, 5'd9, data, 1'b1, size, uns, off);
  endtask

  initial begin
    // Asynchronous reset: outputs must already be clear before any edge.
    #3;
    checkOutput("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    applyStimulus("alu_x5", 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 2'd0);
    idle("idle_after_alu");

    for (int off = 0; off < 4; off++)
      loadStep($sformatf("lb_off%0d", off), 32'h80FF7F01, 2'd0, 1'b0, off[1:0]);
    for (int off = 0; off < 4; off++)
      loadStep($sformatf("lbu_off%0d", off), 32'h80FF7F01, 2'd0, 1'b1, off[1:0]);

    loadStep("lh_off0", 32'h80017FFE, 2'd1, 1'b0, 2'd0);
    loadStep("lh_off2", 32'h80017FFE, 2'd1, 1'b0, 2'd2);
    loadStep("lhu_off2", 32'h80017FFE, 2'd1, 1'b1, 2'd2);

    loadStep("mis_half1", 32'h11223344, 2'd1, 1'b0, 2'd1);
    loadStep("mis_word2", 32'h11223344, 2'd2, 1'b0, 2'd2);
    loadStep("mis_size3", 32'h11223344, 2'd3, 1'b0, 2'd0);
    loadStep("lw_off0", 32'h11223344, 2'd2, 1'b0, 2'd0);

    applyStimulus("write_x0", 1'b1, 1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 2'd0, 1'b0, 2'd0);
    for (int r = 1; r <= 4; r++)
      applyStimulus($sformatf("b2b_x%0d", r), 1'b1, 1'b0, 1'b1, r[4:0],
                    32'hA0000000 + r, 1'b0, 2'd0, 1'b0, 2'd0);

    applyStimulus("pre_halt", 1'b1, 1'b0, 1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 2'd0, 1'b0, 2'd0);
    for (int c = 0; c < 3; c++)
      applyStimulus($sformatf("halt%0d", c), 1'b1, 1'b1, 1'b1, 5'd13, 32'h0BADF00D,
                    1'b0, 2'd0, 1'b0, 2'd0);
    applyStimulus("halt_release", 1'b1, 1'b0, 1'b1, 5'd13, 32'h0BADF00D, 1'b0, 2'd0, 1'b0, 2'd0);

    // Randomized traffic; the 4-bit counter wraps several times here.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($sformatf("rand%0d", i),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                    1'($urandom), 5'($urandom), $urandom, 1'($urandom),
                    2'($urandom), 1'($urandom), 2'($urandom));
    end

    // Reset while an accept is pending: the edge lands inside reset, so no write.
    input_valid_i = 1'b1;
    halt_i = 1'b0;
    input_reg_write_i = 1'b1;
    input_reg_addr_i = 5'd7;
    input_reg_data_i = 32'h77777777;
    input_load_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    exp_write = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_data_known = 1'b1;
    exp_mis = 1'b0;
    exp_count = 0;
    checkOutput("reset_async");
    @(posedge clk_i);
    #1;
    checkOutput("reset_edge");
    input_valid_i = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("post_reset");
    idle("post_reset_idle");
    applyStimulus("post_reset_alu", 1'b1, 1'b0, 1'b1, 5'd3, 32'h00C0FFEE, 1'b0, 2'd0, 1'b0, 2'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Accepts completed results from the load/store stage over a valid/ready handshake.
- Extracts and extends load data, then drives the register-file write port one cycle later.
- Also provides a forwarding view of the in-flight write, a misaligned-load flag and a retired-instruction counter.
- Sits between the load/store stage and the register file, and feeds the decode-stage bypass logic.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low. This polarity and synchronicity are fixed.
- input_valid_i  in  1  upstream result valid.
- input_ready_o  out  1  stage can accept this cycle.
- input_reg_write_i  in  1  result targets a register.
- input_reg_addr_i  in  5  destination register.
- input_reg_data_i  in  32  ALU result, or raw aligned memory word for loads.
- input_load_i  in  1  result is a load.
- input_load_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- input_load_unsigned_i  in  1  zero-extend instead of sign-extend.
- input_load_offset_i  in  2  byte offset of the access within the word.
- halt_i  in  1  debug/stall request; blocks acceptance.
- reg_write_o  out  1  register-file write enable.
- reg_addr_o  out  5  register-file write address.
- reg_data_o  out  32  register-file write data.
- misaligned_o  out  1  one-cycle pulse on a faulting load.
- retired_count_o  out  COUNT_WIDTH  number of non-faulting accepted results.

Behaviour:
- Reset values (while rst_ni=0): reg_write_o=0, reg_addr_o=0, reg_data_o=0, misaligned_o=0, retired_count_o=0. Reset is asynchronous; outputs clear immediately.
- Handshake:
  - input_ready_o = ~halt_i, purely combinational and independent of input_valid_i.
  - accept = input_valid_i & input_ready_o.
  - No internal backpressure: the stage accepts one result per cycle indefinitely.
- Latency: exactly one cycle. Results are registered on the accepting edge and are visible on the outputs in the following cycle.
- Misaligned condition (loads only):
  - size=01 with offset[0]=1;
  - size=10 with offset!=0;
  - size=11 with any offset.
- Registered on each accept:
  - reg_write_o <= input_reg_write_i & (input_reg_addr_i!=0) & ~misaligned.
  - reg_addr_o <= input_reg_addr_i.
  - reg_data_o <= extracted value.
  - misaligned_o <= input_load_i & misaligned.
- Cycle with no accept: reg_write_o<=0 and misaligned_o<=0. reg_addr_o and reg_data_o hold their previous values.
- Extraction (shift s = input_reg_data_i >> 8*offset):
  - Non-load: data passes through unchanged.
  - Byte: s[7:0], extended from bit 7 unless unsigned.
  - Half: s[15:0], extended from bit 15 unless unsigned.
  - Word: full 32 bits.
  - A faulting load produces no write; its data value is don't-care.
- Writes to x0: never asserted on reg_write_o, but the access still counts as retired.
- Retired counter:
  - Increments by 1 on the edge of each accept that is not a faulting load.
  - Wraps from all-ones to 0.
- Forwarding: consumers treat reg_write_o/reg_addr_o/reg_data_o as the current-cycle bypass source. No separate forwarding port exists.
- halt_i asserted:
  - No accept occurs.
  - A result accepted on the previous edge still appears on the outputs normally.
  - Deasserting halt_i resumes acceptance in the same cycle.
- Reset mid-operation: a pending registered write is dropped and no write occurs after release. The counter restarts at 0.

Test Plan:
- Reset, then non-load accept: addr=5, data=0xDEADBEEF, reg_write=1 → next cycle reg_write_o=1, addr 5, data 0xDEADBEEF; retired_count_o=1; following idle cycle reg_write_o=0.
- Load byte, signed, word 0x80FF7F01, offsets 0..3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; same offsets with unsigned → 0x01, 0x7F, 0xFF, 0x80.
- Load half with word 0x8001_7FFE: offset 0 signed → 0x00007FFE; offset 2 signed → 0xFFFF8001; offset 2 unsigned → 0x00008001.
- Misaligned loads: half at offset 1, word at offset 2, size 11 → misaligned_o pulses one cycle each, reg_write_o=0, retired_count_o unchanged.
- Write to x0 with data 0x12345678 → reg_write_o stays 0, retired_count_o increments. Back-to-back accepts to x1..x4 on four consecutive cycles → four consecutive write cycles in order.
- halt_i=1 with input_valid_i=1 for 3 cycles → input_ready_o=0, no writes, counter frozen; release → accept on the same cycle. Separately: preload counter to 0xFFFFFFFF and accept once → counter reads 0; assert rst_ni=0 the cycle after an accept → reg_write_o never asserts.
